ex_issue_stage: RTL and testbench

- ID/EX boundary stage. Sits directly upstream of the 3-bit-control ALU and feeds its Ctrl, A and B inputs.
- Captures decoded RV32I ALU instructions and resolves operands. Operands come from register-file reads, EX/MEM and MEM/WB forwarding, and immediates.
- Decodes funct3/funct7 into the shared ALU control macros (`ADD, `SUB, `AND, `OR, `XOR, `SLL, `SRA, `SRL).
- Holds up to two operations in a skid buffer with valid/ready handshakes on both sides.

---
 rtl/ex_issue_stage.sv | 184 ++++++++++++++++++
 tb/tb_ex_issue_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_issue_stage: ID/EX issue stage that resolves ALU operands and buffers  |
// | ops in a two-entry skid buffer.                              Rev 1.0      |
// +--------------------------------------------------------------------------+

`ifndef ADD
`define ADD 3'b000
`endif
`ifndef SUB
`define SUB 3'b001
`endif
`ifndef AND
`define AND 3'b010
`endif
`ifndef OR
`define OR  3'b011
`endif
`ifndef XOR
`define XOR 3'b100
`endif
`ifndef SLL
`define SLL 3'b101
`endif
`ifndef SRL
`define SRL 3'b110
`endif
`ifndef SRA
`define SRA 3'b111
`endif

module ex_issue_stage #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_imm,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RAW-1:0]  in_rs1,
  input  logic [RAW-1:0]  in_rs2,
  input  logic [XLEN-1:0] in_rf1,
  input  logic [XLEN-1:0] in_rf2,
  input  logic [RAW-1:0]  in_rd,
  input  logic            in_wr_en,
  input  logic            exf_en,
  input  logic [RAW-1:0]  exf_rd,
  input  logic [XLEN-1:0] exf_data,
  input  logic            wb_en,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_ctrl,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [RAW-1:0]  out_rd,
  output logic            out_wr_en,
  output logic            out_illegal
);

  typedef struct packed {
    logic            illegal;
    logic            wr_en;
    logic [RAW-1:0]  rd;
    logic [2:0]      ctrl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic            a_reg;
    logic            b_reg;
    logic            shift;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d, new_e;
  logic   main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic   fire, accept, main_free;

  // The ALU shifts by the whole B value, so shift amounts must be trimmed here.
  function automatic logic [XLEN-1:0] shmask(input logic sh, input logic [XLEN-1:0] v);
    return sh ? {{(XLEN-5){1'b0}}, v[4:0]} : v;
  endfunction

  function automatic logic [XLEN-1:0] resolve(input logic [RAW-1:0] rs,
                                              input logic [XLEN-1:0] rf);
    if (rs == '0)                    return '0;
    else if (exf_en && exf_rd == rs) return exf_data;
    else if (wb_en && wb_rd == rs)   return wb_data;
    else                             return rf;
  endfunction

  function automatic entry_t snoop(input entry_t e);
    entry_t r;
    r = e;
    if (e.a_reg && wb_en && wb_rd == e.rs1) r.a = wb_data;
    if (e.b_reg && wb_en && wb_rd == e.rs2) r.b = shmask(e.shift, wb_data);
    return r;
  endfunction

  always_comb begin
    new_e         = '0;
    new_e.ctrl    = `ADD;
    new_e.illegal = 1'b0;
    new_e.shift   = 1'b0;
    case (in_funct3)
      3'b000:  new_e.ctrl = (!in_is_imm && in_funct7_5) ? `SUB : `ADD;
      3'b001:  begin new_e.ctrl = `SLL; new_e.shift = 1'b1; end
      3'b100:  new_e.ctrl = `XOR;
      3'b101:  begin new_e.ctrl = in_funct7_5 ? `SRA : `SRL; new_e.shift = 1'b1; end
      3'b110:  new_e.ctrl = `OR;
      3'b111:  new_e.ctrl = `AND;
      default: new_e.illegal = 1'b1;
    endcase
    new_e.wr_en = in_wr_en;
    new_e.rd    = in_rd;
    new_e.rs1   = in_rs1;
    new_e.rs2   = in_rs2;
    new_e.a_reg = (in_rs1 != '0);
    new_e.b_reg = !in_is_imm && (in_rs2 != '0);
    new_e.a     = resolve(in_rs1, in_rf1);
    new_e.b     = shmask(new_e.shift, in_is_imm ? in_imm : resolve(in_rs2, in_rf2));
  end

  always_comb begin
    fire      = main_v_q & out_ready;
    accept    = in_valid & in_ready;
    main_free = !main_v_q | fire;
    main_d    = snoop(main_q);
    skid_d    = snoop(skid_q);
    main_v_d  = main_v_q;
    skid_v_d  = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (main_free) begin
      // in_ready is low whenever skid is full, so refill and accept never collide.
      if (skid_v_q) begin
        main_d   = snoop(skid_q);
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (accept) begin
        main_d   = new_e;
        main_v_d = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_d   = new_e;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign in_ready    = !skid_v_q;
  assign out_valid   = main_v_q;
  assign out_ctrl    = main_q.ctrl;
  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_rd      = main_q.rd;
  assign out_wr_en   = main_q.wr_en;
  assign out_illegal = main_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_ex_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ex_issue_stage: directed self-checking bench for ex_issue_stage.       |
// |                                                              Rev 1.0      |
// +--------------------------------------------------------------------------+
module tb_ex_issue_stage;

  localparam logic [2:0] C_ADD = 3'b000, C_SUB = 3'b001, C_AND = 3'b010, C_OR = 3'b011;
  localparam logic [2:0] C_XOR = 3'b100, C_SLL = 3'b101, C_SRL = 3'b110, C_SRA = 3'b111;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_is_imm, in_funct7_5, in_wr_en;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm, in_rf1, in_rf2, exf_data, wb_data;
  logic [4:0]  in_rs1, in_rs2, in_rd, exf_rd, wb_rd;
  logic        exf_en, wb_en, out_valid, out_ready, out_wr_en, out_illegal;
  logic [2:0]  out_ctrl;
  logic [31:0] out_a, out_b;
  logic [4:0]  out_rd;

  int vectors = 0;
  int miscompares = 0;

  ex_issue_stage #(.XLEN(32), .RAW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_imm(in_is_imm),
    .in_funct3(in_funct3), .in_funct7_5(in_funct7_5), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rf1(in_rf1), .in_rf2(in_rf2),
    .in_rd(in_rd), .in_wr_en(in_wr_en),
    .exf_en(exf_en), .exf_rd(exf_rd), .exf_data(exf_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
    .out_wr_en(out_wr_en), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_is_imm = 0; in_funct3 = 0; in_funct7_5 = 0; in_imm = 0;
    in_rs1 = 0; in_rs2 = 0; in_rf1 = 0; in_rf2 = 0; in_rd = 0; in_wr_en = 0;
    exf_en = 0; exf_rd = 0; exf_data = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
    flush = 0;
  endtask

  task automatic offer(input logic imm_sel, input logic [2:0] f3, input logic f7,
                       input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] rf1, input logic [31:0] rf2, input logic [4:0] rd);
    in_valid = 1; in_wr_en = 1; in_is_imm = imm_sel; in_funct3 = f3; in_funct7_5 = f7;
    in_imm = imm; in_rs1 = rs1; in_rs2 = rs2; in_rf1 = rf1; in_rf2 = rf2; in_rd = rd;
  endtask

  logic [2:0] f3_tab [3];
  logic [2:0] ct_tab [3];

  initial begin
    idle();
    out_ready = 1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_rd", out_rd, 0);

    // ADDI x5,x1,-3
    offer(1, 3'b000, 0, 32'hFFFF_FFFD, 1, 0, 10, 0, 5);
    tick();
    chk("addi_valid", out_valid, 1);
    chk("addi_ctrl", out_ctrl, C_ADD);
    chk("addi_a", out_a, 10);
    chk("addi_b", out_b, 32'hFFFF_FFFD);
    chk("addi_rd", out_rd, 5);
    chk("addi_wr_en", out_wr_en, 1);
    chk("addi_illegal", out_illegal, 0);

    // SUB x3,x1,x2 with EX/MEM forward on rs2
    idle();
    offer(0, 3'b000, 1, 0, 1, 2, 20, 99, 3);
    exf_en = 1; exf_rd = 2; exf_data = 7;
    tick();
    chk("sub_ctrl", out_ctrl, C_SUB);
    chk("sub_a", out_a, 20);
    chk("sub_b_fwd", out_b, 7);
    idle();
    offer(0, 3'b000, 1, 0, 1, 0, 20, 99, 3);
    exf_en = 1; exf_rd = 0; exf_data = 7;
    tick();
    chk("sub_b_x0", out_b, 0);
    // EX/MEM beats MEM/WB on rs1; MEM/WB alone on rs2
    idle();
    offer(0, 3'b000, 0, 0, 4, 9, 1, 2, 8);
    exf_en = 1; exf_rd = 4; exf_data = 32'h11;
    wb_en = 1; wb_rd = 4; wb_data = 32'h22;
    tick();
    chk("prio_a_exf", out_a, 32'h11);
    chk("prio_b_rf", out_b, 2);
    idle();
    offer(0, 3'b000, 0, 0, 4, 9, 1, 2, 8);
    wb_en = 1; wb_rd = 9; wb_data = 32'h33;
    tick();
    chk("wbfwd_b", out_b, 32'h33);
    chk("wbfwd_a_rf", out_a, 1);

    // Shifts with masking
    idle();
    offer(1, 3'b101, 1, 32'h405, 1, 0, 10, 0, 4);
    tick();
    chk("srai_ctrl", out_ctrl, C_SRA);
    chk("srai_b", out_b, 5);
    idle();
    offer(0, 3'b001, 0, 0, 1, 7, 10, 32'hFFFF_FF21, 4);
    tick();
    chk("sll_ctrl", out_ctrl, C_SLL);
    chk("sll_b", out_b, 1);
    idle();
    offer(0, 3'b101, 0, 0, 1, 7, 10, 32'h0000_003F, 4);
    tick();
    chk("srl_ctrl", out_ctrl, C_SRL);
    chk("srl_b", out_b, 32'h1F);

    f3_tab[0] = 3'b100; f3_tab[1] = 3'b110; f3_tab[2] = 3'b111;
    ct_tab[0] = C_XOR;  ct_tab[1] = C_OR;   ct_tab[2] = C_AND;
    for (int i = 0; i < 3; i++) begin
      idle();
      offer(0, f3_tab[i], 1, 0, 1, 2, 32'hA5, 32'h5A, 6);
      tick();
      chk($sformatf("logic_ctrl_%0d", i), out_ctrl, ct_tab[i]);
      chk($sformatf("logic_b_%0d", i), out_b, 32'h5A);
    end
    idle();
    tick();
    chk("drain_valid", out_valid, 0);

    // Back-pressure and skid
    out_ready = 0;
    offer(0, 3'b000, 0, 0, 1, 2, 1, 1, 11);
    tick();
    chk("bp_op1_rd", out_rd, 11);
    chk("bp_in_ready1", in_ready, 1);
    offer(0, 3'b000, 0, 0, 1, 2, 2, 2, 12);
    tick();
    chk("bp_hold_rd", out_rd, 11);
    chk("bp_hold_a", out_a, 1);
    chk("bp_in_ready0", in_ready, 0);
    offer(0, 3'b000, 0, 0, 1, 2, 3, 3, 13);
    tick();
    chk("bp_hold2_rd", out_rd, 11);
    chk("bp_in_ready0b", in_ready, 0);
    out_ready = 1;
    tick();
    chk("bp_op2_valid", out_valid, 1);
    chk("bp_op2_rd", out_rd, 12);
    chk("bp_op2_a", out_a, 2);
    chk("bp_in_ready_back", in_ready, 1);
    tick();
    chk("bp_op3_valid", out_valid, 1);
    chk("bp_op3_rd", out_rd, 13);
    idle();
    tick();
    chk("bp_empty", out_valid, 0);

    // Writeback snoop on held entries (main and skid)
    out_ready = 0;
    offer(1, 3'b000, 0, 32'h123, 6, 6, 32'h10, 0, 7);
    tick();
    chk("snp_a_before", out_a, 32'h10);
    offer(0, 3'b001, 0, 0, 0, 6, 0, 3, 9);
    tick();
    idle();
    wb_en = 1; wb_rd = 6; wb_data = 32'hFFFF_FF47;
    tick();
    chk("snp_a_after", out_a, 32'hFFFF_FF47);
    chk("snp_imm_kept", out_b, 32'h123);
    idle();
    out_ready = 1;
    tick();
    chk("snp_skid_rd", out_rd, 9);
    chk("snp_skid_ctrl", out_ctrl, C_SLL);
    chk("snp_skid_b", out_b, 7);
    chk("snp_skid_a", out_a, 0);
    tick();
    chk("snp_empty", out_valid, 0);

    // Flush with two ops held plus one offered
    out_ready = 0;
    offer(0, 3'b000, 0, 0, 1, 2, 1, 1, 21);
    tick();
    offer(0, 3'b000, 0, 0, 1, 2, 1, 1, 22);
    tick();
    offer(0, 3'b000, 0, 0, 1, 2, 1, 1, 23);
    flush = 1;
    tick();
    chk("fl_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    idle();
    out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("fl_quiet_%0d", i), out_valid, 0);
    end

    // Flush while the stage can accept: offered op is dropped
    out_ready = 0;
    offer(0, 3'b000, 0, 0, 1, 2, 1, 1, 24);
    tick();
    offer(0, 3'b000, 0, 0, 1, 2, 1, 1, 25);
    flush = 1;
    tick();
    chk("fl2_valid", out_valid, 0);
    chk("fl2_in_ready", in_ready, 1);
    idle();
    tick();
    chk("fl2_dropped", out_valid, 0);

    // Unsupported funct3 still flows
    out_ready = 1;
    offer(0, 3'b010, 0, 0, 1, 2, 5, 6, 26);
    tick();
    chk("ill010_valid", out_valid, 1);
    chk("ill010_flag", out_illegal, 1);
    chk("ill010_ctrl", out_ctrl, C_ADD);
    offer(1, 3'b011, 1, 32'h44, 1, 0, 5, 0, 27);
    tick();
    chk("ill011_flag", out_illegal, 1);
    chk("ill011_ctrl", out_ctrl, C_ADD);
    chk("ill011_rd", out_rd, 27);
    idle();
    tick();
    chk("end_empty", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
